// File: rtl/wb_retry_master.sv
// Single-outstanding Wishbone B4 classic master: re-issues RTY-terminated cycles
// up to MAX_RETRY times and bounds each attempt with a TIMEOUT-cycle wait counter.
module wb_retry_master #(
  parameter int AW        = 32,
  parameter int DW        = 32,
  parameter int TGW       = 16,
  parameter int MAX_RETRY = 3,
  parameter int TIMEOUT   = 64
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_we,
  input  logic [AW-1:0]     cmd_adr,
  input  logic [DW-1:0]     cmd_dat,
  input  logic [DW/8-1:0]   cmd_sel,
  input  logic              cmd_lock,
  input  logic [TGW-1:0]    cmd_tga,
  input  logic [TGW-1:0]    cmd_tgc,
  input  logic [TGW-1:0]    cmd_tgd,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DW-1:0]     rsp_dat,
  output logic [TGW-1:0]    rsp_tgd,
  output logic [1:0]        rsp_status,
  output logic [3:0]        rsp_retries,
  output logic [AW-1:0]     ADR_O,
  output logic [DW-1:0]     DAT_O,
  output logic [DW/8-1:0]   SEL_O,
  output logic              WE_O,
  output logic              CYC_O,
  output logic              STB_O,
  output logic              LOCK_O,
  output logic [TGW-1:0]    TGA_O,
  output logic [TGW-1:0]    TGC_O,
  output logic [TGW-1:0]    TGD_O,
  input  logic [DW-1:0]     DAT_I,
  input  logic [TGW-1:0]    TGD_I,
  input  logic              ACK_I,
  input  logic              ERR_I,
  input  logic              RTY_I
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, GAP = 2'd2, RESP = 2'd3} state_t;

  localparam logic [1:0]  ST_OK     = 2'd0;
  localparam logic [1:0]  ST_ERR    = 2'd1;
  localparam logic [1:0]  ST_RTY    = 2'd2;
  localparam logic [1:0]  ST_TMO    = 2'd3;
  localparam logic [15:0] WAIT_LAST = 16'(TIMEOUT - 1);
  localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);

  state_t          state_r;
  logic [15:0]     wait_r;
  logic [3:0]      retry_r;

  logic            term_s;
  logic            retry_s;
  logic [1:0]      term_status_s;
  logic [DW-1:0]   term_dat_s;
  logic [TGW-1:0]  term_tgd_s;

  // Classify the current bus cycle: ERR beats RTY beats ACK, timeout only if none.
  always_comb begin
    term_s        = 1'b0;
    retry_s       = 1'b0;
    term_status_s = ST_OK;
    term_dat_s    = {DW{1'b0}};
    term_tgd_s    = TGD_I;
    if (state_r == BUS && STB_O) begin
      if (ERR_I) begin
        term_s        = 1'b1;
        term_status_s = ST_ERR;
      end else if (RTY_I) begin
        if (retry_r == RETRY_MAX) begin
          term_s        = 1'b1;
          term_status_s = ST_RTY;
        end else begin
          retry_s = 1'b1;
        end
      end else if (ACK_I) begin
        term_s        = 1'b1;
        term_status_s = ST_OK;
        term_dat_s    = WE_O ? {DW{1'b0}} : DAT_I;
      end else if (wait_r == WAIT_LAST) begin
        term_s        = 1'b1;
        term_status_s = ST_TMO;
        term_tgd_s    = {TGW{1'b0}};
      end else begin
        term_s = 1'b0;
      end
    end else begin
      term_s = 1'b0;
    end
  end

  // Transaction FSM with all bus and response outputs registered.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      wait_r      <= 16'd0;
      retry_r     <= 4'd0;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_dat     <= {DW{1'b0}};
      rsp_tgd     <= {TGW{1'b0}};
      rsp_status  <= 2'd0;
      rsp_retries <= 4'd0;
      ADR_O       <= {AW{1'b0}};
      DAT_O       <= {DW{1'b0}};
      SEL_O       <= {(DW/8){1'b0}};
      WE_O        <= 1'b0;
      CYC_O       <= 1'b0;
      STB_O       <= 1'b0;
      LOCK_O      <= 1'b0;
      TGA_O       <= {TGW{1'b0}};
      TGC_O       <= {TGW{1'b0}};
      TGD_O       <= {TGW{1'b0}};
    end else begin
      case (state_r)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            ADR_O     <= cmd_adr;
            DAT_O     <= cmd_dat;
            SEL_O     <= cmd_sel;
            WE_O      <= cmd_we;
            LOCK_O    <= cmd_lock;
            TGA_O     <= cmd_tga;
            TGC_O     <= cmd_tgc;
            TGD_O     <= cmd_tgd;
            CYC_O     <= 1'b1;
            STB_O     <= 1'b1;
            wait_r    <= 16'd0;
            retry_r   <= 4'd0;
            state_r   <= BUS;
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        BUS: begin
          if (term_s) begin
            CYC_O       <= 1'b0;
            STB_O       <= 1'b0;
            LOCK_O      <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_status  <= term_status_s;
            rsp_dat     <= term_dat_s;
            rsp_tgd     <= term_tgd_s;
            rsp_retries <= retry_r;
            state_r     <= RESP;
          end else if (retry_s) begin
            // A locked transfer keeps the bus claimed through the retry gap.
            retry_r <= retry_r + 4'd1;
            STB_O   <= 1'b0;
            CYC_O   <= LOCK_O;
            state_r <= GAP;
          end else begin
            wait_r <= wait_r + 16'd1;
          end
        end
        GAP: begin
          CYC_O   <= 1'b1;
          STB_O   <= 1'b1;
          wait_r  <= 16'd0;
          state_r <= BUS;
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state_r   <= IDLE;
          end else begin
            rsp_valid <= 1'b1;
          end
        end
        default: begin
          cmd_ready <= 1'b0;
          CYC_O     <= 1'b0;
          STB_O     <= 1'b0;
          LOCK_O    <= 1'b0;
          rsp_valid <= 1'b0;
          state_r   <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_wb_retry_master.sv
// Bench for wb_retry_master: scripted Wishbone slave per attempt, expected response
// derived from the retry/timeout rules by walking the attempt script.
module tb_wb_retry_master;

  localparam int TMO  = 8;
  localparam int MAXR = 3;

  localparam int K_NONE = 0;
  localparam int K_ACK  = 1;
  localparam int K_ERR  = 2;
  localparam int K_RTY  = 3;
  localparam int K_EA   = 4;
  localparam int K_RA   = 5;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_we, cmd_lock;
  logic [31:0] cmd_adr, cmd_dat;
  logic [3:0]  cmd_sel;
  logic [15:0] cmd_tga, cmd_tgc, cmd_tgd;
  logic        rsp_valid, rsp_ready;
  logic [31:0] rsp_dat;
  logic [15:0] rsp_tgd;
  logic [1:0]  rsp_status;
  logic [3:0]  rsp_retries;
  logic [31:0] ADR_O, DAT_O, DAT_I;
  logic [3:0]  SEL_O;
  logic        WE_O, CYC_O, STB_O, LOCK_O;
  logic [15:0] TGA_O, TGC_O, TGD_O, TGD_I;
  logic        ACK_I, ERR_I, RTY_I;

  int total = 0;
  int bad   = 0;

  int          pk   [16];
  int          pw   [16];
  logic [31:0] pdat [16];
  logic [15:0] ptgd [16];

  wb_retry_master #(.AW(32), .DW(32), .TGW(16), .MAX_RETRY(MAXR), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_we(cmd_we), .cmd_adr(cmd_adr),
    .cmd_dat(cmd_dat), .cmd_sel(cmd_sel), .cmd_lock(cmd_lock), .cmd_tga(cmd_tga),
    .cmd_tgc(cmd_tgc), .cmd_tgd(cmd_tgd),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_dat(rsp_dat), .rsp_tgd(rsp_tgd),
    .rsp_status(rsp_status), .rsp_retries(rsp_retries),
    .ADR_O(ADR_O), .DAT_O(DAT_O), .SEL_O(SEL_O), .WE_O(WE_O), .CYC_O(CYC_O), .STB_O(STB_O),
    .LOCK_O(LOCK_O), .TGA_O(TGA_O), .TGC_O(TGC_O), .TGD_O(TGD_O),
    .DAT_I(DAT_I), .TGD_I(TGD_I), .ACK_I(ACK_I), .ERR_I(ERR_I), .RTY_I(RTY_I)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic rand_plan();
    int kinds [9];
    kinds = '{K_ACK, K_ACK, K_ERR, K_RTY, K_RTY, K_RTY, K_EA, K_RA, K_NONE};
    for (int i = 0; i < 16; i++) begin
      pk[i]   = kinds[$urandom_range(0, 8)];
      pw[i]   = $urandom_range(0, TMO + 1);
      pdat[i] = $urandom;
      ptgd[i] = 16'($urandom);
    end
  endtask

  task automatic run_txn(input string name, input logic we, input logic [31:0] adr,
                         input logic [31:0] dat, input logic [3:0] sel, input logic lock,
                         input int hold);
    int retries, att, w, stb_cnt, gap_cnt, hold_bad, gap_bad, stab_bad, exp_stb, exp_gap, n;
    bit done, drove, was_stb;
    logic [1:0]  exp_st;
    logic [31:0] exp_dat;
    logic [15:0] exp_tgd, tga, tgc, tgd;
    logic [31:0] s_dat;
    logic [15:0] s_tgd;
    logic [1:0]  s_st;
    logic [3:0]  s_rt;

    // Walk the attempt script through the retry / timeout rules.
    retries = 0; att = 0; exp_stb = 0; exp_gap = 0; done = 0;
    exp_st = 2'd0; exp_dat = 32'd0; exp_tgd = 16'd0;
    while (!done) begin
      if (pk[att] == K_NONE || pw[att] >= TMO) begin
        exp_stb += TMO; exp_st = 2'd3; exp_dat = 32'd0; exp_tgd = 16'd0; done = 1;
      end else begin
        exp_stb += pw[att] + 1;
        if (pk[att] == K_ERR || pk[att] == K_EA) begin
          exp_st = 2'd1; exp_dat = 32'd0; exp_tgd = ptgd[att]; done = 1;
        end else if (pk[att] == K_RTY || pk[att] == K_RA) begin
          if (retries == MAXR) begin
            exp_st = 2'd2; exp_dat = 32'd0; exp_tgd = ptgd[att]; done = 1;
          end else begin
            retries++; exp_gap++; att++;
          end
        end else begin
          exp_st = 2'd0; exp_dat = we ? 32'd0 : pdat[att]; exp_tgd = ptgd[att]; done = 1;
        end
      end
    end

    n = 0;
    while (!cmd_ready && n < 10) begin
      @(posedge clk); @(negedge clk); n++;
    end
    chk({name, ".cmd_ready"}, 64'(cmd_ready), 64'd1);
    tga = 16'($urandom); tgc = 16'($urandom); tgd = 16'($urandom);
    cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
    cmd_lock = lock; cmd_tga = tga; cmd_tgc = tgc; cmd_tgd = tgd;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0; cmd_adr = $urandom; cmd_dat = $urandom; cmd_tga = 16'($urandom);

    att = 0; w = 0; stb_cnt = 0; gap_cnt = 0; hold_bad = 0; gap_bad = 0;
    for (int c = 0; c < 300 && !rsp_valid; c++) begin
      ACK_I = 1'b0; ERR_I = 1'b0; RTY_I = 1'b0;
      DAT_I = $urandom; TGD_I = 16'($urandom);
      drove = 0; was_stb = STB_O;
      if (STB_O) begin
        stb_cnt++;
        if (CYC_O !== 1'b1 || ADR_O !== adr || DAT_O !== dat || SEL_O !== sel || WE_O !== we ||
            LOCK_O !== lock || TGA_O !== tga || TGC_O !== tgc || TGD_O !== tgd)
          hold_bad++;
        if (pk[att] != K_NONE && w == pw[att]) begin
          drove = 1; DAT_I = pdat[att]; TGD_I = ptgd[att];
          ACK_I = (pk[att] == K_ACK || pk[att] == K_EA || pk[att] == K_RA);
          ERR_I = (pk[att] == K_ERR || pk[att] == K_EA);
          RTY_I = (pk[att] == K_RTY || pk[att] == K_RA);
        end
      end else begin
        // Retry gap: stray terminations must be ignored.
        gap_cnt++;
        if (CYC_O !== lock) gap_bad++;
        {ACK_I, ERR_I, RTY_I} = 3'($urandom);
      end
      @(posedge clk);
      if (drove) begin
        att = (att < 15) ? att + 1 : 15; w = 0;
      end else if (was_stb) begin
        w++;
      end
      @(negedge clk);
    end
    ACK_I = 1'b0; ERR_I = 1'b0; RTY_I = 1'b0;

    chk({name, ".rsp_valid"},   64'(rsp_valid),   64'd1);
    chk({name, ".status"},      64'(rsp_status),  64'(exp_st));
    chk({name, ".retries"},     64'(rsp_retries), 64'(retries));
    chk({name, ".rsp_dat"},     64'(rsp_dat),     64'(exp_dat));
    chk({name, ".rsp_tgd"},     64'(rsp_tgd),     64'(exp_tgd));
    chk({name, ".stb_cycles"},  64'(stb_cnt),     64'(exp_stb));
    chk({name, ".gap_cycles"},  64'(gap_cnt),     64'(exp_gap));
    chk({name, ".hold"},        64'(hold_bad),    64'd0);
    chk({name, ".gap_cyc"},     64'(gap_bad),     64'd0);
    chk({name, ".bus_idle"},    64'({CYC_O, STB_O, LOCK_O, cmd_ready}), 64'd0);

    s_dat = rsp_dat; s_tgd = rsp_tgd; s_st = rsp_status; s_rt = rsp_retries;
    stab_bad = 0;
    rsp_ready = 1'b0;
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); @(negedge clk);
      if (rsp_valid !== 1'b1 || rsp_dat !== s_dat || rsp_tgd !== s_tgd || rsp_status !== s_st ||
          rsp_retries !== s_rt || cmd_ready !== 1'b0 || CYC_O !== 1'b0)
        stab_bad++;
    end
    if (hold > 0) chk({name, ".rsp_stable"}, 64'(stab_bad), 64'd0);
    rsp_ready = 1'b1;
    @(posedge clk); @(negedge clk);
    rsp_ready = 1'b0;
    chk({name, ".post_hs"}, 64'({rsp_valid, cmd_ready}), 64'b01);
  endtask

  initial begin
    int bad_rsp;
    rst = 1'b1; cmd_valid = 1'b0; cmd_we = 1'b0; cmd_lock = 1'b0; cmd_adr = 32'd0;
    cmd_dat = 32'd0; cmd_sel = 4'd0; cmd_tga = 16'd0; cmd_tgc = 16'd0; cmd_tgd = 16'd0;
    rsp_ready = 1'b0; DAT_I = 32'd0; TGD_I = 16'd0; ACK_I = 1'b0; ERR_I = 1'b0; RTY_I = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst.ctl", 64'({CYC_O, STB_O, WE_O, LOCK_O, rsp_valid, cmd_ready}), 64'd0);
    chk("rst.adr_dat", {ADR_O, DAT_O}, 64'd0);
    chk("rst.sel_tg", 64'({SEL_O, TGA_O, TGC_O, TGD_O}), 64'd0);
    chk("rst.rsp", 64'({rsp_dat, rsp_tgd, rsp_status, rsp_retries}), 64'd0);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("rst.ready_after", 64'(cmd_ready), 64'd1);

    rand_plan(); pk[0] = K_ACK; pw[0] = 2;
    run_txn("wr_ack2", 1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 1'b0, 0);

    rand_plan(); pk[0] = K_RTY; pw[0] = 0; pk[1] = K_RTY; pw[1] = 0;
    pk[2] = K_ACK; pw[2] = 0; pdat[2] = 32'h12345678;
    run_txn("rd_rty2", 1'b0, 32'h200, 32'h0, 4'hF, 1'b0, 0);

    rand_plan();
    for (int i = 0; i < 4; i++) begin
      pk[i] = K_RTY; pw[i] = $urandom_range(0, TMO - 1);
    end
    run_txn("rty_exhaust", 1'b0, 32'h300, 32'h0, 4'h3, 1'b1, 0);

    rand_plan(); pk[0] = K_NONE;
    run_txn("timeout", 1'b1, 32'h400, 32'hCAFE0001, 4'h1, 1'b0, 0);

    rand_plan(); pk[0] = K_ACK; pw[0] = TMO - 1;
    run_txn("ack_at_limit", 1'b0, 32'h404, 32'h0, 4'hF, 1'b0, 0);

    rand_plan(); pk[0] = K_EA; pw[0] = 1;
    run_txn("err_ack_hold", 1'b0, 32'h500, 32'h0, 4'hF, 1'b0, 5);

    rand_plan(); pk[0] = K_RA; pw[0] = 0; pk[1] = K_ACK; pw[1] = 0;
    run_txn("rty_over_ack", 1'b0, 32'h504, 32'h0, 4'hC, 1'b1, 0);

    for (int t = 0; t < 25; t++) begin
      rand_plan();
      run_txn("rand", 1'($urandom), $urandom, $urandom, 4'($urandom), 1'($urandom),
              $urandom_range(0, 3));
    end

    // Reset in the middle of a locked bus cycle.
    rand_plan(); pk[0] = K_NONE;
    cmd_valid = 1'b1; cmd_we = 1'b1; cmd_lock = 1'b1; cmd_adr = 32'h600;
    @(posedge clk); @(negedge clk);
    cmd_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    chk("rstmid.before", 64'({CYC_O, LOCK_O}), 64'b11);
    rst = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("rstmid.after", 64'({CYC_O, STB_O, LOCK_O, rsp_valid, cmd_ready}), 64'd0);
    rst = 1'b0;
    bad_rsp = 0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk); @(negedge clk);
      if (rsp_valid !== 1'b0 || CYC_O !== 1'b0) bad_rsp++;
    end
    chk("rstmid.silent", 64'(bad_rsp), 64'd0);
    chk("rstmid.ready", 64'(cmd_ready), 64'd1);

    rand_plan(); pk[0] = K_ACK; pw[0] = 0;
    run_txn("after_rst", 1'b0, 32'h700, 32'h0, 4'hF, 1'b0, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/wb_retry_master.md
WB_RETRY_MASTER -- requirements
Module: wb_retry_master

Interface
REQ-001 Parameters: AW=32, address width. DW=32, data width (multiple of 8). TGW=16, tag width. MAX_RETRY=3, RTY re-issues before failure (0..15). TIMEOUT=64, wait cycles before abort (2..65535).
REQ-002 Ports (name dir width meaning): clk in 1 clock; all logic on posedge clk.
REQ-003 rst in 1 reset; synchronous, active-high.
REQ-004 cmd_valid in 1, cmd_ready out 1: command handshake.
REQ-005 cmd_we in 1, cmd_adr in AW, cmd_dat in DW, cmd_sel in DW/8, cmd_lock in 1, cmd_tga in TGW, cmd_tgc in TGW, cmd_tgd in TGW: command fields.
REQ-006 rsp_valid out 1, rsp_ready in 1: response handshake.
REQ-007 rsp_dat out DW, rsp_tgd out TGW: read data and tag.
REQ-008 rsp_status out 2: 0=OK, 1=ERR, 2=RTY_EXHAUSTED, 3=TIMEOUT.
REQ-009 rsp_retries out 4: RTY count seen for this transaction.
REQ-010 Wishbone B4 classic master: ADR_O out AW, DAT_O out DW, SEL_O out DW/8, WE_O, CYC_O, STB_O, LOCK_O out 1; TGA_O, TGC_O, TGD_O out TGW; DAT_I in DW, TGD_I in TGW; ACK_I, ERR_I, RTY_I in 1.

Function
REQ-011 States: IDLE, BUS, GAP, RESP; one transaction outstanding at a time.
REQ-012 cmd_ready SHALL be 1 only in IDLE; accept at cycle N moves to BUS; all Wishbone outputs registered from command fields; CYC_O=STB_O=1 from N+1.
REQ-013 BUS: CYC_O, STB_O, all address/data/tag outputs held constant until termination.
REQ-014 Termination: ERR_I, RTY_I or ACK_I sampled 1 while STB_O=1; priority ERR > RTY > ACK.
REQ-015 ACK at cycle M: CYC_O=STB_O=0 at M+1; rsp_valid=1 at M+1, status OK, rsp_dat=DAT_I and rsp_tgd=TGD_I captured at M (reads; writes give rsp_dat=0).
REQ-016 ERR at M: as REQ-015 with status ERR, rsp_dat=0.
REQ-017 RTY at M with retry count < MAX_RETRY: count+1, enter GAP; CYC_O=STB_O=0 for exactly one cycle (M+1), re-assert at M+2 with identical outputs.
REQ-018 RTY at M with count = MAX_RETRY: abort as REQ-015, status RTY_EXHAUSTED, rsp_retries=MAX_RETRY.
REQ-019 Wait counter: reset to 0 on each STB_O assertion, +1 per BUS cycle without termination; reaching TIMEOUT drops CYC_O/STB_O next cycle, status TIMEOUT.
REQ-020 Termination on the same cycle the counter reaches TIMEOUT is honoured; timeout not reported.
REQ-021 RESP: rsp_valid and all rsp_* held until rsp_valid&rsp_ready; then IDLE; cmd_ready=1 the following cycle.
REQ-022 LOCK_O=cmd_lock for the whole transaction, held across GAP; CYC_O only in GAP SHALL stay 1 when LOCK_O=1.
REQ-023 ACK_I/ERR_I/RTY_I while STB_O=0 SHALL be ignored.
REQ-024 Minimum transaction with zero-wait ACK: accept N, STB_O N+1, ACK N+1, rsp_valid N+2.

Reset
REQ-025 rst=1 at any edge: state IDLE, CYC_O=STB_O=WE_O=LOCK_O=0, ADR_O/DAT_O/SEL_O/TG*_O=0, rsp_valid=0, rsp_*=0, counters=0, cmd_ready=0 while rst=1.
REQ-026 Reset mid-transaction aborts it silently: no response, CYC_O=0 the cycle after rst sampled.

Verification
REQ-027 Write adr=0x100 dat=0xDEADBEEF sel=0xF, ACK after 2 waits -> STB_O 3 cycles, status 0, rsp_retries 0.
REQ-028 Read adr=0x200, slave RTY twice then ACK with DAT_I=0x12345678 -> two 1-cycle STB_O gaps, rsp_dat=0x12345678, rsp_retries 2.
REQ-029 MAX_RETRY=3, slave always RTY -> 4 STB_O attempts, status 2.
REQ-030 TIMEOUT=8, no termination -> STB_O high exactly 8 cycles, status 3; ACK on cycle 8 instead -> status 0.
REQ-031 ERR and ACK together -> status 1; rsp_ready held 0 for 5 cycles -> rsp_* stable, cmd_ready 0.
REQ-032 rst asserted during BUS with cmd_lock=1 -> CYC_O, LOCK_O 0 next cycle, no rsp_valid.
